// File: rtl/line_buffer_scheduler.sv
// Ring scheduler for the HDMI-input line buffer: picks the write block, commits finished rows to readout, drops rows when the ring is full.
// Optional LINE_BUFFER_DROP_COUNT_EN adds O_drop_count, a per-frame saturating count of dropped rows.
module line_buffer_scheduler #(
    parameter int BLOCK_COUNT = 2,
    parameter int MAX_HEIGHT  = 1080
) (
    input  logic                           I_rgb_clk,
    input  logic                           I_rst_n,
    input  logic                           I_swap_trigger,
    input  logic                           I_vs_detected,
    input  logic                           I_image_valid,
    input  logic                           I_read_start,
    input  logic                           I_read_done,
    output logic [$clog2(BLOCK_COUNT)-1:0] O_write_block,
    output logic [$clog2(BLOCK_COUNT)-1:0] O_read_block,
    output logic                           O_read_valid,
    output logic                           O_read_first_row,
    output logic [$clog2(MAX_HEIGHT)-1:0]  O_row_index,
    output logic                           O_overflow
`ifdef LINE_BUFFER_DROP_COUNT_EN
    ,
    output logic [15:0]                    O_drop_count
`endif
);
    localparam int BW = $clog2(BLOCK_COUNT);
    localparam int RW = $clog2(MAX_HEIGHT);
    localparam int CW = BW + 1;
    localparam logic [BW-1:0] LAST_BLK   = BW'(BLOCK_COUNT - 1);
    localparam logic [CW-1:0] MAX_COMMIT = CW'(BLOCK_COUNT - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(MAX_HEIGHT - 1);

    logic [BW-1:0]                  wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]                  committed_q, committed_d, committed_a;
    logic                           reading_q, reading_d, reading_a;
    logic [RW-1:0]                  rc_q, rc_d;
    logic [BLOCK_COUNT-1:0]         first_q, first_d;
    logic [BLOCK_COUNT-1:0][RW-1:0] row_q, row_d;
    logic                           valid_q, valid_d;
    logic                           rd_first_q, rd_first_d;
    logic [RW-1:0]                  rd_row_q, rd_row_d;
    logic                           ov_q, ov_d;
    logic                           done_eff, start_eff, commit, next_free;

    always_comb begin
        // A same-cycle done is retired first so both the free check and a
        // back-to-back start see the released block.
        done_eff    = I_read_done & reading_q;
        reading_a   = reading_q & ~done_eff;
        committed_a = committed_q - CW'(done_eff);
        start_eff   = I_read_start & ~reading_a & (committed_a != '0);
        next_free   = committed_a < MAX_COMMIT;
        commit      = I_swap_trigger & I_image_valid & next_free;
        ov_d        = I_swap_trigger & I_image_valid & ~next_free;

        rc_d = rc_q;
        if (I_swap_trigger) begin
            if (I_vs_detected) begin
                rc_d = RW'(1);
            end else if (rc_q != LAST_ROW) begin
                rc_d = rc_q + RW'(1);
            end
        end

        first_d = first_q;
        row_d   = row_q;
        wp_d    = wp_q;
        if (commit) begin
            first_d[wp_q] = I_vs_detected;
            row_d[wp_q]   = I_vs_detected ? '0 : rc_q;
            wp_d          = (wp_q == LAST_BLK) ? '0 : wp_q + BW'(1);
        end

        rp_d = rp_q;
        if (start_eff) begin
            rp_d = (rp_q == LAST_BLK) ? '0 : rp_q + BW'(1);
        end

        reading_d   = reading_a | start_eff;
        committed_d = committed_a + CW'(commit);
        valid_d     = committed_d > CW'(reading_d);
        rd_first_d  = first_d[rp_d];
        rd_row_d    = row_d[rp_d];
    end

    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wp_q        <= '0;
            rp_q        <= '0;
            committed_q <= '0;
            reading_q   <= 1'b0;
            rc_q        <= '0;
            first_q     <= '0;
            row_q       <= '0;
            valid_q     <= 1'b0;
            rd_first_q  <= 1'b0;
            rd_row_q    <= '0;
            ov_q        <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            committed_q <= committed_d;
            reading_q   <= reading_d;
            rc_q        <= rc_d;
            first_q     <= first_d;
            row_q       <= row_d;
            valid_q     <= valid_d;
            rd_first_q  <= rd_first_d;
            rd_row_q    <= rd_row_d;
            ov_q        <= ov_d;
        end
    end

    assign O_write_block    = wp_q;
    assign O_read_block     = rp_q;
    assign O_read_valid     = valid_q;
    assign O_read_first_row = rd_first_q;
    assign O_row_index      = rd_row_q;
    assign O_overflow       = ov_q;

`ifdef LINE_BUFFER_DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Counts alongside the overflow decision so it lands with the pulse; frame clear wins.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (I_swap_trigger && I_vs_detected) begin
            drop_cnt_d = '0;
        end else if (ov_d && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign O_drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Bench for line_buffer_scheduler: directed scenarios plus randomized traffic against a queue-based model.
module tb_line_buffer_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, sw, vs, iv, rs, rd;
    logic [0:0]  wb2, rb2;
    logic        v2, f2, ov2;
    logic [10:0] ri2;
    logic [1:0]  wb4, rb4;
    logic        v4, f4, ov4;
    logic [2:0]  ri4;
`ifdef LINE_BUFFER_DROP_COUNT_EN
    logic [15:0] dc2, dc4;
`endif

    line_buffer_scheduler #(.BLOCK_COUNT(2), .MAX_HEIGHT(1080)) dut2 (
        .I_rgb_clk(clk), .I_rst_n(rst_n), .I_swap_trigger(sw), .I_vs_detected(vs),
        .I_image_valid(iv), .I_read_start(rs), .I_read_done(rd),
        .O_write_block(wb2), .O_read_block(rb2), .O_read_valid(v2),
        .O_read_first_row(f2), .O_row_index(ri2), .O_overflow(ov2)
`ifdef LINE_BUFFER_DROP_COUNT_EN
        , .O_drop_count(dc2)
`endif
    );

    line_buffer_scheduler #(.BLOCK_COUNT(4), .MAX_HEIGHT(6)) dut4 (
        .I_rgb_clk(clk), .I_rst_n(rst_n), .I_swap_trigger(sw), .I_vs_detected(vs),
        .I_image_valid(iv), .I_read_start(rs), .I_read_done(rd),
        .O_write_block(wb4), .O_read_block(rb4), .O_read_valid(v4),
        .O_read_first_row(f4), .O_row_index(ri4), .O_overflow(ov4)
`ifdef LINE_BUFFER_DROP_COUNT_EN
        , .O_drop_count(dc4)
`endif
    );

    // Both DUTs see the same stimulus; sel4 picks which one is being checked.
    bit          sel4;
    logic [31:0] o_wb, o_rb, o_ri, o_dc;
    logic        o_v, o_f, o_ov;
    always_comb begin
        o_wb = sel4 ? 32'(wb4) : 32'(wb2);
        o_rb = sel4 ? 32'(rb4) : 32'(rb2);
        o_ri = sel4 ? 32'(ri4) : 32'(ri2);
        o_v  = sel4 ? v4 : v2;
        o_f  = sel4 ? f4 : f2;
        o_ov = sel4 ? ov4 : ov2;
        o_dc = '0;
`ifdef LINE_BUFFER_DROP_COUNT_EN
        o_dc = sel4 ? 32'(dc4) : 32'(dc2);
`endif
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a FIFO of committed-but-unclaimed rows plus a reading flag.
    typedef struct {
        int blk;
        bit first;
        int row;
    } tag_t;
    tag_t mq[$];
    int   m_bc, m_maxh, m_wp, m_rc, m_drop;
    bit   m_reading, m_ov;

    task automatic model_reset(input int bc, input int maxh);
        mq.delete();
        m_bc = bc; m_maxh = maxh;
        m_wp = 0; m_rc = 0; m_drop = 0;
        m_reading = 0; m_ov = 0;
    endtask

    function automatic int exp_rb();
        return (mq.size() > 0) ? mq[0].blk : m_wp;
    endfunction

    task automatic model_step(input bit s, input bit v_, input bit i, input bit r_s, input bit r_d);
        tag_t t;
        bit   can_start;
        m_ov = 0;
        if (r_d && m_reading) m_reading = 0;
        can_start = (mq.size() > 0) && !m_reading;
        if (s) begin
            t.blk = m_wp;
            if (v_) begin
                t.first = 1; t.row = 0; m_rc = 1;
            end else begin
                t.first = 0; t.row = m_rc;
                if (m_rc < m_maxh - 1) m_rc++;
            end
            if (i) begin
                if (mq.size() + int'(m_reading) < m_bc - 1) begin
                    mq.push_back(t);
                    m_wp = (m_wp + 1) % m_bc;
                end else begin
                    m_ov = 1;
                end
            end
            if (v_) m_drop = 0;
            else if (m_ov && m_drop < 65535) m_drop++;
        end
        if (r_s && can_start) begin
            void'(mq.pop_front());
            m_reading = 1;
        end
    endtask

    // Drives one cycle starting at a negedge; returns at the next negedge with inputs idle.
    task automatic step(input bit s, input bit v_, input bit i, input bit r_s, input bit r_d);
        sw = s; vs = v_; iv = i; rs = r_s; rd = r_d;
        model_step(s, v_, i, r_s, r_d);
        @(posedge clk);
        @(negedge clk);
        sw = 0; vs = 0; iv = 0; rs = 0; rd = 0;
    endtask

    task automatic do_reset(input bit use4);
        sel4  = use4;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        if (use4) model_reset(4, 6);
        else model_reset(2, 1080);
    endtask

    task automatic test_reset();
        do_reset(0);
        n_checks++;
        if (o_wb !== 0 || o_rb !== 0 || o_ri !== 0) begin
            n_errors++;
            $display("FAIL reset_ptrs: wb=%0d rb=%0d ri=%0d expected 0 0 0", o_wb, o_rb, o_ri);
        end
        n_checks++;
        if (o_v !== 1'b0 || o_f !== 1'b0 || o_ov !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: valid=%b first=%b ov=%b expected 0 0 0", o_v, o_f, o_ov);
        end
        n_checks++;
        if (o_dc !== 0) begin
            n_errors++;
            $display("FAIL reset_dropcnt: got %0d expected 0", o_dc);
        end
    endtask

    task automatic test_overflow();
        do_reset(0);
        step(1, 0, 1, 0, 0);
        n_checks++;
        if (o_wb !== 1 || o_v !== 1'b1 || o_ov !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_first_commit: wb=%0d valid=%b ov=%b expected 1 1 0", o_wb, o_v, o_ov);
        end
        step(1, 0, 1, 0, 0);
        n_checks++;
        if (o_ov !== 1'b1 || o_wb !== 1) begin
            n_errors++;
            $display("FAIL ovf_second: ov=%b wb=%0d expected 1 1", o_ov, o_wb);
        end
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (o_ov !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_pulse_width: ov=%b expected 0", o_ov);
        end
        step(1, 0, 1, 0, 0);
        n_checks++;
        if (o_ov !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_third: ov=%b expected 1", o_ov);
        end
`ifdef LINE_BUFFER_DROP_COUNT_EN
        n_checks++;
        if (o_dc !== 2) begin
            n_errors++;
            $display("FAIL ovf_dropcnt: got %0d expected 2", o_dc);
        end
`endif
    endtask

    task automatic test_tags();
        do_reset(0);
        step(1, 1, 1, 0, 0);
        n_checks++;
        if (o_v !== 1'b1 || o_f !== 1'b1 || o_ri !== 0) begin
            n_errors++;
            $display("FAIL tag_row0: valid=%b first=%b row=%0d expected 1 1 0", o_v, o_f, o_ri);
        end
        step(0, 0, 0, 1, 0);
        n_checks++;
        if (o_v !== 1'b0) begin
            n_errors++;
            $display("FAIL tag_claimed: valid=%b expected 0", o_v);
        end
        step(1, 0, 1, 0, 1);
        n_checks++;
        if (o_v !== 1'b1 || o_f !== 1'b0 || o_ri !== 1 || o_rb !== 1) begin
            n_errors++;
            $display("FAIL tag_row1: valid=%b first=%b row=%0d rb=%0d expected 1 0 1 1", o_v, o_f, o_ri, o_rb);
        end
        step(0, 0, 0, 1, 0);
        step(1, 0, 1, 0, 1);
        n_checks++;
        if (o_v !== 1'b1 || o_f !== 1'b0 || o_ri !== 2 || o_rb !== 0) begin
            n_errors++;
            $display("FAIL tag_row2: valid=%b first=%b row=%0d rb=%0d expected 1 0 2 0", o_v, o_f, o_ri, o_rb);
        end
    endtask

    task automatic test_done_and_swap_full();
        do_reset(0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 1, 0, 1);
        n_checks++;
        if (o_ov !== 1'b0 || o_wb !== 0 || o_v !== 1'b1 || o_rb !== 1) begin
            n_errors++;
            $display("FAIL done_swap_full: ov=%b wb=%0d valid=%b rb=%0d expected 0 0 1 1", o_ov, o_wb, o_v, o_rb);
        end
    endtask

    task automatic test_invalid_swap();
        do_reset(0);
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (o_wb !== 0 || o_v !== 1'b0 || o_ov !== 1'b0) begin
            n_errors++;
            $display("FAIL invalid_swap: wb=%0d valid=%b ov=%b expected 0 0 0", o_wb, o_v, o_ov);
        end
        step(1, 0, 1, 0, 0);
        n_checks++;
        if (o_ri !== 1 || o_f !== 1'b0) begin
            n_errors++;
            $display("FAIL invalid_rc_adv: row=%0d first=%b expected 1 0", o_ri, o_f);
        end
    endtask

    task automatic test_bc4_order();
        do_reset(1);
        repeat (3) step(1, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (o_rb !== k || o_v !== 1'b1) begin
                n_errors++;
                $display("FAIL bc4_order_%0d: rb=%0d valid=%b expected %0d 1", k, o_rb, o_v, k);
            end
            step(0, 0, 0, 1, 0);
            if (k < 2) step(0, 0, 0, 0, 1);
        end
        n_checks++;
        if (o_v !== 1'b0) begin
            n_errors++;
            $display("FAIL bc4_drained: valid=%b expected 0", o_v);
        end
    endtask

    task automatic test_async_reset();
        do_reset(1);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_wb !== 0 || o_rb !== 0 || o_v !== 1'b0 || o_f !== 1'b0 || o_ri !== 0 || o_ov !== 1'b0 || o_dc !== 0) begin
            n_errors++;
            $display("FAIL async_reset: wb=%0d rb=%0d valid=%b first=%b row=%0d ov=%b dc=%0d expected all 0",
                     o_wb, o_rb, o_v, o_f, o_ri, o_ov, o_dc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset(4, 6);
    endtask

    task automatic test_random(input bit use4);
        do_reset(use4);
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4);
            n_checks++;
            if (o_wb !== m_wp || o_rb !== exp_rb() || o_v !== (mq.size() > 0) || o_ov !== m_ov || o_dc !== 0 && o_dc !== m_drop) begin
                n_errors++;
                $display("FAIL rand_bc%0d_c%0d: wb=%0d rb=%0d v=%b ov=%b dc=%0d expected %0d %0d %0d %0d %0d",
                         m_bc, c, o_wb, o_rb, o_v, o_ov, o_dc, m_wp, exp_rb(), mq.size() > 0, m_ov, m_drop);
            end
`ifdef LINE_BUFFER_DROP_COUNT_EN
            n_checks++;
            if (o_dc !== m_drop) begin
                n_errors++;
                $display("FAIL rand_dropcnt_c%0d: got %0d expected %0d", c, o_dc, m_drop);
            end
`endif
            if (mq.size() > 0) begin
                n_checks++;
                if (o_f !== mq[0].first || o_ri !== mq[0].row) begin
                    n_errors++;
                    $display("FAIL rand_tag_bc%0d_c%0d: first=%b row=%0d expected %b %0d",
                             m_bc, c, o_f, o_ri, mq[0].first, mq[0].row);
                end
            end
        end
    endtask

    initial begin
        sw = 0; vs = 0; iv = 0; rs = 0; rd = 0; rst_n = 1'b0; sel4 = 0;
        @(negedge clk);
        test_reset();
        test_overflow();
        test_tags();
        test_done_and_swap_full();
        test_invalid_swap();
        test_bc4_order();
        test_async_reset();
        test_random(0);
        test_random(1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
